bitty_driver: RTL and testbench

BITTY_DRIVER -- requirements
Module: bitty_driver

---
 rtl/bitty_pkg.sv | 17 +
 rtl/bitty_driver.sv | 182 ++++++++++++++++++
 tb/tb_bitty_driver.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitty_pkg.sv
// Shared definitions for the bitty program driver: state encoding and instruction width.
package bitty_pkg;

  localparam int INSTR_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_MEM,
    ISSUE,
    LOAD,
    CALC,
    WAIT_DONE,
    NEXT
  } drv_state_e;

endpackage

// File: rtl/bitty_driver.sv
// Program driver: fetches instructions from a synchronous program memory and walks
// the control unit through issue/load/calc, accumulating results and a checksum.
module bitty_driver
  import bitty_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  run_len,
  input  logic               abort,
  output logic [ADDR_W-1:0]  instr_addr,
  input  logic [INSTR_W-1:0] instr_data,
  output logic [INSTR_W-1:0] instruction,
  output logic               en_i,
  output logic               en_s,
  output logic               en_c,
  input  logic               done,
  input  logic [INSTR_W-1:0] d_out,
  output logic [INSTR_W-1:0] result,
  output logic               result_valid,
  output logic [ADDR_W-1:0]  op_count,
  output logic [INSTR_W-1:0] checksum,
  output logic               busy,
  output logic               finished,
  output logic               error
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  drv_state_e         state_q;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  run_len_q;
  logic [ADDR_W-1:0]  instr_addr_q;
  logic [INSTR_W-1:0] instr_q;
  logic               en_i_q, en_s_q, en_c_q;
  logic [INSTR_W-1:0] result_q;
  logic               result_valid_q;
  logic [ADDR_W-1:0]  op_count_q, op_count_d;
  logic [INSTR_W-1:0] checksum_q, checksum_d;
  logic               busy_q, finished_q, error_q;
  logic               abort_pend_q;
  logic [TW-1:0]      wait_cnt_q;

  always_comb begin
    pc_d       = pc_q + ADDR_W'(1);
    op_count_d = op_count_q + ADDR_W'(1);
    checksum_d = checksum_q + d_out;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      pc_q           <= '0;
      run_len_q      <= '0;
      instr_addr_q   <= '0;
      instr_q        <= '0;
      en_i_q         <= 1'b0;
      en_s_q         <= 1'b0;
      en_c_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      op_count_q     <= '0;
      checksum_q     <= '0;
      busy_q         <= 1'b0;
      finished_q     <= 1'b0;
      error_q        <= 1'b0;
      abort_pend_q   <= 1'b0;
      wait_cnt_q     <= '0;
    end else begin
      en_i_q         <= 1'b0;
      en_s_q         <= 1'b0;
      en_c_q         <= 1'b0;
      result_valid_q <= 1'b0;
      finished_q     <= 1'b0;

      // Abort is only remembered here; the in-flight op always runs to completion.
      if (state_q != IDLE && abort) begin
        abort_pend_q <= 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (start) begin
            run_len_q    <= run_len;
            pc_q         <= '0;
            op_count_q   <= '0;
            checksum_q   <= '0;
            error_q      <= 1'b0;
            abort_pend_q <= 1'b0;
            if (run_len == '0) begin
              finished_q <= 1'b1;
            end else begin
              instr_addr_q <= '0;
              busy_q       <= 1'b1;
              state_q      <= FETCH;
            end
          end
        end

        FETCH: begin
          state_q <= WAIT_MEM;
        end

        WAIT_MEM: begin
          instr_q <= instr_data;
          en_i_q  <= 1'b1;
          state_q <= ISSUE;
        end

        ISSUE: begin
          en_s_q  <= 1'b1;
          state_q <= LOAD;
        end

        LOAD: begin
          en_c_q  <= 1'b1;
          state_q <= CALC;
        end

        CALC: begin
          wait_cnt_q <= '0;
          state_q    <= WAIT_DONE;
        end

        WAIT_DONE: begin
          if (done) begin
            result_q       <= d_out;
            result_valid_q <= 1'b1;
            op_count_q     <= op_count_d;
            checksum_q     <= checksum_d;
            state_q        <= NEXT;
          end else if (wait_cnt_q == TO_LAST) begin
            error_q      <= 1'b1;
            finished_q   <= 1'b1;
            busy_q       <= 1'b0;
            abort_pend_q <= 1'b0;
            state_q      <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + TW'(1);
          end
        end

        NEXT: begin
          // An abort arriving in this very cycle still counts as pending.
          if (op_count_q == run_len_q || abort_pend_q || abort) begin
            finished_q   <= 1'b1;
            busy_q       <= 1'b0;
            abort_pend_q <= 1'b0;
            state_q      <= IDLE;
          end else begin
            pc_q         <= pc_d;
            instr_addr_q <= pc_d;
            state_q      <= FETCH;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign instr_addr   = instr_addr_q;
  assign instruction  = instr_q;
  assign en_i         = en_i_q;
  assign en_s         = en_s_q;
  assign en_c         = en_c_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign op_count     = op_count_q;
  assign checksum     = checksum_q;
  assign busy         = busy_q;
  assign finished     = finished_q;
  assign error        = error_q;

endmodule

// File: tb/tb_bitty_driver.sv
// Bench for bitty_driver: timeline model per run, random programs/latencies/aborts.
module tb_bitty_driver;
  import bitty_pkg::*;

  localparam int AW   = 8;
  localparam int T    = 4;
  localparam int MAXC = 4096;
  localparam int NMEM = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] run_len = '0;
  logic          abort = 1'b0;
  logic [AW-1:0] instr_addr;
  logic [15:0]   instr_data = '0;
  logic [15:0]   instruction;
  logic          en_i, en_s, en_c;
  logic          done = 1'b0;
  logic [15:0]   d_out = '0;
  logic [15:0]   result;
  logic          result_valid;
  logic [AW-1:0] op_count;
  logic [15:0]   checksum;
  logic          busy, finished, error;

  always #5 clk = ~clk;

  bitty_driver #(.ADDR_W(AW), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .start(start), .run_len(run_len), .abort(abort),
    .instr_addr(instr_addr), .instr_data(instr_data), .instruction(instruction),
    .en_i(en_i), .en_s(en_s), .en_c(en_c), .done(done), .d_out(d_out),
    .result(result), .result_valid(result_valid), .op_count(op_count),
    .checksum(checksum), .busy(busy), .finished(finished), .error(error)
  );

  typedef struct {
    logic          busy;
    logic [2:0]    en;
    logic          fin;
    logic          err;
    logic          rv;
    logic [AW-1:0] op;
    logic [15:0]   cks;
    logic [15:0]   res;
    bit            addr_chk;
    logic [AW-1:0] addr;
    bit            ins_chk;
    logic [15:0]   ins;
  } exp_t;

  exp_t        tr [MAXC];
  logic [15:0] mem [NMEM];
  int          lat_arr [NMEM];
  int          abort_at = -1, restart_at = -1;
  int          trace_len = 0, new_len = 0, end_c = 0;
  int          cyc = 0, base_cyc = 0, run_id = 0;
  logic [15:0] last_result = '0;
  int          errors = 0, checks = 0;

  // Control unit behaviour: byte swap plus a constant
  function automatic logic [15:0] cu_f(input logic [15:0] x);
    return {x[7:0], x[15:8]} + 16'h1357;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous program memory, one-cycle read latency
  always @(posedge clk) instr_data <= mem[instr_addr];

  // Control-unit responder: done pulses lat cycles after en_c (lat 0 = never)
  int          rsp_k = 0, rsp_cnt = 0, seen_id = 0;
  logic [15:0] rsp_ins = '0;
  always @(negedge clk) begin
    if (run_id != seen_id) begin
      seen_id = run_id;
      rsp_k   = 0;
      rsp_cnt = 0;
    end
    done  = 1'b0;
    d_out = 16'($urandom);
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        done  = 1'b1;
        d_out = cu_f(rsp_ins);
      end
    end
    if (en_i) rsp_ins = instruction;
    if (en_c) begin
      rsp_cnt = lat_arr[rsp_k];
      rsp_k++;
    end
  end

  // Cycle-by-cycle compare against the predicted timeline
  always @(negedge clk) begin
    int c;
    c = cyc - base_cyc;
    if (c >= 0 && c < trace_len) begin
      chk($sformatf("busy@%0d", c), busy, tr[c].busy);
      chk($sformatf("en@%0d", c), {en_i, en_s, en_c}, tr[c].en);
      chk($sformatf("finished@%0d", c), finished, tr[c].fin);
      chk($sformatf("error@%0d", c), error, tr[c].err);
      chk($sformatf("result_valid@%0d", c), result_valid, tr[c].rv);
      chk($sformatf("op_count@%0d", c), op_count, tr[c].op);
      chk($sformatf("checksum@%0d", c), checksum, tr[c].cks);
      chk($sformatf("result@%0d", c), result, tr[c].res);
      if (tr[c].addr_chk) chk($sformatf("instr_addr@%0d", c), instr_addr, tr[c].addr);
      if (tr[c].ins_chk) chk($sformatf("instruction@%0d", c), instruction, tr[c].ins);
    end
  end

  // Timeline: each op costs FETCH..CALC (5), lat WAIT_DONE cycles, then NEXT.
  task automatic build_trace(input int L);
    exp_t        e;
    int          c, n, lat;
    logic [15:0] d;
    bit          stop;
    e.busy = 1'b1; e.en = '0; e.fin = 1'b0; e.err = 1'b0; e.rv = 1'b0;
    e.op = '0; e.cks = '0; e.res = last_result;
    e.addr_chk = 0; e.addr = '0; e.ins_chk = 0; e.ins = '0;
    if (L == 0) begin
      e.busy = 1'b0; e.fin = 1'b1; tr[0] = e;
      e.fin = 1'b0; tr[1] = e;
      new_len = 2; end_c = 0;
      return;
    end
    c = 0;
    for (int k = 0; ; k++) begin
      e.addr = AW'(k);
      e.ins  = mem[k % NMEM];
      e.rv   = 1'b0;
      e.addr_chk = 1; tr[c] = e; e.addr_chk = 0;
      tr[c+1] = e;
      e.ins_chk = 1;
      e.en = 3'b100; tr[c+2] = e;
      e.en = 3'b010; tr[c+3] = e;
      e.en = 3'b001; tr[c+4] = e;
      e.en = 3'b000;
      lat = lat_arr[k];
      if (lat == 0) begin
        for (int j = 1; j <= T; j++) tr[c+4+j] = e;
        e.ins_chk = 0; e.busy = 1'b0; e.err = 1'b1; e.fin = 1'b1; tr[c+5+T] = e;
        e.fin = 1'b0; tr[c+6+T] = e;
        end_c = c + 5 + T; new_len = c + 7 + T;
        break;
      end
      for (int j = 1; j <= lat; j++) tr[c+4+j] = e;
      e.ins_chk = 0;
      n = c + 5 + lat;
      d = cu_f(mem[k % NMEM]);
      e.res = d; e.op = e.op + 1'b1; e.cks = e.cks + d; e.rv = 1'b1;
      tr[n] = e;
      stop = (int'(e.op) == L) || (abort_at >= 0 && abort_at <= n);
      if (stop) begin
        e.rv = 1'b0; e.busy = 1'b0; e.fin = 1'b1; tr[n+1] = e;
        e.fin = 1'b0; tr[n+2] = e;
        end_c = n + 1; new_len = n + 3;
        break;
      end
      c = n + 1;
    end
    last_result = e.res;
  endtask

  // Assumes trace already built and restart_at/abort_at chosen.
  task automatic drive_run(input int L);
    @(negedge clk);
    start = 1'b1; run_len = AW'(L); abort = 1'b0;
    base_cyc = cyc + 1; trace_len = new_len; run_id++;
    @(negedge clk);
    for (int c = 0; c < new_len; c++) begin
      start   = (c == restart_at);
      run_len = AW'($urandom);
      abort   = (c == abort_at);
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0;
    $display("run L=%0d abort_at=%0d restart_at=%0d -> op_count=%0d checksum=%h error=%0b",
             L, abort_at, restart_at, op_count, checksum, error);
  endtask

  task automatic run(input int L);
    build_trace(L);
    drive_run(L);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_en"}, {en_i, en_s, en_c}, 0);
    chk({tag, "_finished"}, finished, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_result_valid"}, result_valid, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_op_count"}, op_count, 0);
    chk({tag, "_checksum"}, checksum, 0);
    chk({tag, "_instr_addr"}, instr_addr, 0);
    chk({tag, "_instruction"}, instruction, 0);
  endtask

  initial begin
    int L, r;
    for (int i = 0; i < NMEM; i++) begin
      mem[i] = 16'($urandom);
      lat_arr[i] = 2;
    end
    mem[0] = 16'h2004; mem[1] = 16'h4408; mem[2] = 16'h6010;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;

    // Reference program of three instructions, nominal latency
    run(3);
    chk("prog3_checksum", checksum, 16'h56C9);
    chk("prog3_result", result, 16'h23B7);
    chk("prog3_op_count", op_count, 3);

    // Zero-length run
    run(0);
    chk("len0_op_count", op_count, 0);

    // done never arrives
    lat_arr[0] = 0;
    run(3);
    chk("timeout_error", error, 1);
    chk("timeout_result", result, 16'h23B7);
    chk("timeout_op_count", op_count, 0);
    lat_arr[0] = 2;

    // Abort during LOAD of instruction 0
    abort_at = 3;
    run(5);
    chk("abort_op_count", op_count, 1);
    abort_at = -1;

    // Start re-asserted while busy
    build_trace(2);
    restart_at = 3;
    drive_run(2);
    chk("restart_op_count", op_count, 2);
    restart_at = -1;

    // Reset during CALC of instruction 0
    build_trace(3);
    @(negedge clk);
    start = 1'b1; run_len = 8'd3; run_id++;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_en_c", en_c, 1);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    @(negedge clk);
    reset = 1'b1;
    last_result = '0;
    repeat (3) @(negedge clk);
    run(1);
    chk("post_reset_op_count", op_count, 1);

    // Maximum run length
    for (int i = 0; i < NMEM; i++) lat_arr[i] = $urandom_range(1, T);
    run(255);
    chk("maxlen_op_count", op_count, 8'hFF);

    // Randomized runs
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < NMEM; i++) mem[i] = 16'($urandom);
      L = $urandom_range(0, 12);
      for (int k = 0; k < 13; k++) begin
        r = $urandom_range(0, 19);
        lat_arr[k] = (r == 0) ? 0 : $urandom_range(1, T);
      end
      abort_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 8 * L + 8) : -1;
      build_trace(L);
      restart_at = (end_c > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, end_c - 1) : -1;
      drive_run(L);
      abort_at = -1; restart_at = -1;
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
